// File: rtl/win_lbuf_pkg.sv
// -----------------------------------------------------------------------------
// win_lbuf_pkg
//   Shared types and default parameter values for the win_lbuf sliding-window
//   generator.
//   - win_lbuf_state_e : frame-control FSM state (also driven out of the top
//                        on wl_state_o for observation).
//   - WL_DEF_*         : default values of the top-level parameters.
// -----------------------------------------------------------------------------
package win_lbuf_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,  // waiting for a start of frame
    FILL = 2'd1,  // first K-1 rows are loading into the line buffer
    RUN  = 2'd2,  // window positions are being produced
    DONE = 2'd3   // last pixel of the frame accepted
  } win_lbuf_state_e;

  localparam int WL_DEF_DATA_WIDTH = 32;
  localparam int WL_DEF_IMG_W      = 32;
  localparam int WL_DEF_IMG_H      = 32;
  localparam int WL_DEF_KSIZE      = 5;
  localparam int WL_DEF_NUM_CH     = 1;

endpackage

// File: rtl/win_lbuf_lbuf_row.sv
// -----------------------------------------------------------------------------
// lbuf_row
//   One image-row delay line: DEPTH entries of DATA_WIDTH bits that shift by
//   one position on every enabled cycle. The tap is the oldest entry, i.e. the
//   pixel accepted DEPTH enables ago (same column, previous row when
//   DEPTH = image width). Storage is deliberately not reset.
//   Ports:
//     clk  in   clock (rising edge)
//     en   in   shift enable (one accepted pixel)
//     din  in   pixel entering the line
//     tap  out  pixel leaving the line
// -----------------------------------------------------------------------------
module lbuf_row #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 32
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] tap
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      mem[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        mem[i] <= mem[i-1];
      end
    end
  end

  assign tap = mem[DEPTH-1];

endmodule

// File: rtl/win_lbuf.sv
// -----------------------------------------------------------------------------
// win_lbuf
//   Multi-channel line buffer and KSIZE x KSIZE sliding-window generator.
//   A row-major pixel stream per channel is accepted; KSIZE-1 previous rows
//   are held in lbuf_row delay lines and a full window per channel is
//   presented, with its top-left output coordinate, one cycle after the pixel
//   that completes it.
//
//   Handshake: wl_en is a valid with no ready. Every cycle with wl_en high
//   carries one pixel; it is accepted if a frame is open (FILL/RUN) or if
//   wl_sof_i is high, otherwise it is dropped with no side effect.
//
//   Ports:
//     wl_clk        in   clock (rising edge)
//     wl_rst_b      in   asynchronous active-low reset
//     wl_en         in   pixel valid
//     wl_sof_i      in   start of frame, this pixel is (0,0)
//     wl_data_i     in   [NUM_CH][DATA_WIDTH] pixel per channel
//     wl_win_o      out  [NUM_CH][KSIZE][KSIZE][DATA_WIDTH] window, [0][0] oldest
//     wl_win_vld_o  out  one-cycle pulse per window
//     wl_orow_o     out  window top row
//     wl_ocol_o     out  window left column
//     wl_eof_o      out  last window of the frame (with wl_win_vld_o)
//     wl_state_o    out  current FSM state
//
//   Build option: define WIN_LBUF_STRIDE2_EN to emit only windows whose
//   output row and column are both even (stride 2). Buffering is unchanged.
// -----------------------------------------------------------------------------
module win_lbuf
  import win_lbuf_pkg::*;
#(
  parameter int DATA_WIDTH = WL_DEF_DATA_WIDTH,
  parameter int IMG_W      = WL_DEF_IMG_W,
  parameter int IMG_H      = WL_DEF_IMG_H,
  parameter int KSIZE      = WL_DEF_KSIZE,
  parameter int NUM_CH     = WL_DEF_NUM_CH
) (
  input  logic                                                  wl_clk,
  input  logic                                                  wl_rst_b,
  input  logic                                                  wl_en,
  input  logic                                                  wl_sof_i,
  input  logic [NUM_CH-1:0][DATA_WIDTH-1:0]                     wl_data_i,
  output logic [NUM_CH-1:0][KSIZE-1:0][KSIZE-1:0][DATA_WIDTH-1:0] wl_win_o,
  output logic                                                  wl_win_vld_o,
  output logic [$clog2(IMG_H)-1:0]                              wl_orow_o,
  output logic [$clog2(IMG_W)-1:0]                              wl_ocol_o,
  output logic                                                  wl_eof_o,
  output win_lbuf_state_e                                       wl_state_o
);

  localparam int RW = $clog2(IMG_H);
  localparam int CW = $clog2(IMG_W);
  localparam int NL = KSIZE - 1;

  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_KM1  = RW'(KSIZE - 1);
  localparam logic [CW-1:0] COL_KM1  = CW'(KSIZE - 1);

`ifdef WIN_LBUF_STRIDE2_EN
  // Last emitted window sits at the largest even coordinate.
  localparam logic [RW-1:0] EOF_OROW = RW'(((IMG_H - KSIZE) / 2) * 2);
  localparam logic [CW-1:0] EOF_OCOL = CW'(((IMG_W - KSIZE) / 2) * 2);
`else
  localparam logic [RW-1:0] EOF_OROW = RW'(IMG_H - KSIZE);
  localparam logic [CW-1:0] EOF_OCOL = CW'(IMG_W - KSIZE);
`endif

  win_lbuf_state_e state_q;
  logic [RW-1:0]   row_q;
  logic [CW-1:0]   col_q;

  logic            vld_q;
  logic [RW-1:0]   orow_q;
  logic [CW-1:0]   ocol_q;
  logic            eof_q;

  logic [NUM_CH-1:0][KSIZE-1:0][KSIZE-1:0][DATA_WIDTH-1:0] win_q;

  // ---------------------------------------------------------------------------
  // Accept and coordinate of the current pixel. A start of frame forces the
  // pixel to (0,0) whatever the counters hold, which is how a mid-frame sof
  // abandons the old frame.
  // ---------------------------------------------------------------------------
  logic          accept;
  logic [RW-1:0] cur_r;
  logic [CW-1:0] cur_c;
  logic          col_last;
  logic          row_last;
  logic [RW-1:0] orow_n;
  logic [CW-1:0] ocol_n;
  logic          win_ok;
  logic          eof_n;

  always_comb begin
    accept   = wl_en && (wl_sof_i || (state_q == FILL) || (state_q == RUN));
    cur_r    = wl_sof_i ? '0 : row_q;
    cur_c    = wl_sof_i ? '0 : col_q;
    col_last = (cur_c == COL_LAST);
    row_last = (cur_r == ROW_LAST);
    orow_n   = cur_r - ROW_KM1;
    ocol_n   = cur_c - COL_KM1;
    // A window is complete once K-1 rows of this frame are in the line
    // buffer and K columns of the current row are in the window registers,
    // so no stale-frame pixel can be inside it.
    win_ok   = accept && (cur_r >= ROW_KM1) && (cur_c >= COL_KM1);
`ifdef WIN_LBUF_STRIDE2_EN
    win_ok   = win_ok && !orow_n[0] && !ocol_n[0];
`endif
    eof_n    = win_ok && (orow_n == EOF_OROW) && (ocol_n == EOF_OCOL);
  end

  // ---------------------------------------------------------------------------
  // Frame FSM, pixel counters and registered window-status outputs.
  // ---------------------------------------------------------------------------
  always_ff @(posedge wl_clk or negedge wl_rst_b) begin
    if (!wl_rst_b) begin
      state_q <= IDLE;
      row_q   <= '0;
      col_q   <= '0;
      vld_q   <= 1'b0;
      orow_q  <= '0;
      ocol_q  <= '0;
      eof_q   <= 1'b0;
    end else begin
      vld_q <= win_ok;
      eof_q <= eof_n;
      if (win_ok) begin
        orow_q <= orow_n;
        ocol_q <= ocol_n;
      end

      if (accept) begin
        if (col_last) begin
          col_q <= '0;
          row_q <= row_last ? '0 : cur_r + 1'b1;
        end else begin
          col_q <= cur_c + 1'b1;
          row_q <= cur_r;
        end

        if (wl_sof_i) begin
          state_q <= FILL;
        end else begin
          case (state_q)
            FILL: if ((cur_r == ROW_KM1) && (cur_c == '0)) state_q <= RUN;
            RUN:  if (row_last && col_last)                 state_q <= DONE;
            default: state_q <= state_q;
          endcase
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Line buffer: NL chained delay lines per channel. Line 0 is fed by the
  // input pixel, line l by the tap of line l-1, so line l's tap is the pixel
  // l+1 rows above the current one.
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] line_in  [NUM_CH][NL];
  logic [DATA_WIDTH-1:0] line_tap [NUM_CH][NL];

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    for (genvar l = 0; l < NL; l++) begin : g_line
      if (l == 0) begin : g_head
        assign line_in[ch][l] = wl_data_i[ch];
      end else begin : g_chain
        assign line_in[ch][l] = line_tap[ch][l-1];
      end

      lbuf_row #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (IMG_W)
      ) u_lbuf_row (
        .clk (wl_clk),
        .en  (accept),
        .din (line_in[ch][l]),
        .tap (line_tap[ch][l])
      );
    end
  end

  // ---------------------------------------------------------------------------
  // Window registers: shift left one column per accepted pixel; the right
  // column takes the line taps (oldest row at the top) and the new pixel.
  // ---------------------------------------------------------------------------
  always_ff @(posedge wl_clk or negedge wl_rst_b) begin
    if (!wl_rst_b) begin
      win_q <= '0;
    end else if (accept) begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        for (int r = 0; r < KSIZE; r++) begin
          for (int c = 0; c < KSIZE - 1; c++) begin
            win_q[ch][r][c] <= win_q[ch][r][c+1];
          end
        end
        for (int r = 0; r < KSIZE - 1; r++) begin
          win_q[ch][r][KSIZE-1] <= line_tap[ch][KSIZE-2-r];
        end
        win_q[ch][KSIZE-1][KSIZE-1] <= wl_data_i[ch];
      end
    end
  end

  assign wl_win_o     = win_q;
  assign wl_win_vld_o = vld_q;
  assign wl_orow_o    = orow_q;
  assign wl_ocol_o    = ocol_q;
  assign wl_eof_o     = eof_q;
  assign wl_state_o   = state_q;

endmodule

// File: tb/tb_win_lbuf.sv
// -----------------------------------------------------------------------------
// tb_win_lbuf
//   Directed bench for win_lbuf with IMG_W=IMG_H=8, KSIZE=3, NUM_CH=2,
//   8-bit pixels. Pixel (r,c) = (r*16+c) ^ key on ch0, its inverse on ch1;
//   the key distinguishes frames so stale data would be visible.
//   Define WIN_LBUF_STRIDE2_EN for both DUT and bench to check stride 2.
// -----------------------------------------------------------------------------
module tb_win_lbuf;
  import win_lbuf_pkg::*;

  localparam int DW = 8;
  localparam int W  = 8;
  localparam int H  = 8;
  localparam int K  = 3;
  localparam int NC = 2;

`ifdef WIN_LBUF_STRIDE2_EN
  localparam int STRIDE = 2;
  localparam int EXP_COUNT = 9;
  localparam logic [DW-1:0] EXP_LAST_PIX = 8'h66;
`else
  localparam int STRIDE = 1;
  localparam int EXP_COUNT = 36;
  localparam logic [DW-1:0] EXP_LAST_PIX = 8'h77;
`endif
  localparam int LAST_OR = ((H - K) / STRIDE) * STRIDE;
  localparam int LAST_OC = ((W - K) / STRIDE) * STRIDE;

  typedef logic [NC-1:0][K-1:0][K-1:0][DW-1:0] win_t;
  typedef struct packed {
    logic [2:0] orow;
    logic [2:0] ocol;
    logic       eof;
    win_t       win;
  } rec_t;

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  logic rst_b = 1'b0;
  always #5 clk = ~clk;

  logic                   wl_en = 1'b0;
  logic                   wl_sof_i = 1'b0;
  logic [NC-1:0][DW-1:0]  wl_data_i = '0;
  win_t                   wl_win_o;
  logic                   wl_win_vld_o;
  logic [2:0]             wl_orow_o;
  logic [2:0]             wl_ocol_o;
  logic                   wl_eof_o;
  win_lbuf_state_e        wl_state_o;

  win_lbuf #(
    .DATA_WIDTH (DW),
    .IMG_W      (W),
    .IMG_H      (H),
    .KSIZE      (K),
    .NUM_CH     (NC)
  ) dut (
    .wl_clk       (clk),
    .wl_rst_b     (rst_b),
    .wl_en        (wl_en),
    .wl_sof_i     (wl_sof_i),
    .wl_data_i    (wl_data_i),
    .wl_win_o     (wl_win_o),
    .wl_win_vld_o (wl_win_vld_o),
    .wl_orow_o    (wl_orow_o),
    .wl_ocol_o    (wl_ocol_o),
    .wl_eof_o     (wl_eof_o),
    .wl_state_o   (wl_state_o)
  );

  int tests  = 0;
  int failed = 0;
  int cyc    = 0;
  int pix22_cyc = 0;
  int gap_viol  = 0;
  int eof_stray = 0;
  logic en_q = 1'b0;

  rec_t mon_q[$];
  int   mon_cyc[$];
  rec_t exp_q[$];

  always @(posedge clk) begin
    cyc  <= cyc + 1;
    en_q <= wl_en;
  end

  // Monitor: records every window pulse, sampled mid-cycle.
  always @(negedge clk) begin
    if (wl_win_vld_o) begin
      mon_q.push_back('{orow: wl_orow_o, ocol: wl_ocol_o, eof: wl_eof_o, win: wl_win_o});
      mon_cyc.push_back(cyc);
      if (!en_q) gap_viol++;
    end
    if (wl_eof_o && !wl_win_vld_o) eof_stray++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------- model
  function automatic logic [DW-1:0] pix(int ch, int r, int c, logic [DW-1:0] key);
    logic [DW-1:0] v;
    v = DW'(r * 16 + c) ^ key;
    return (ch == 0) ? v : ~v;
  endfunction

  function automatic win_t make_win(int orow, int ocol, logic [DW-1:0] key);
    win_t w;
    for (int ch = 0; ch < NC; ch++)
      for (int i = 0; i < K; i++)
        for (int j = 0; j < K; j++)
          w[ch][i][j] = pix(ch, orow + i, ocol + j, key);
    return w;
  endfunction

  // Expected windows for a frame sent from (0,0) up to (last_r,last_c).
  function automatic void expect_frame(logic [DW-1:0] key, int last_r, int last_c);
    rec_t e;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        if (r > last_r || (r == last_r && c > last_c)) return;
        if (r >= K - 1 && c >= K - 1 &&
            ((r - K + 1) % STRIDE == 0) && ((c - K + 1) % STRIDE == 0)) begin
          e.orow = 3'(r - K + 1);
          e.ocol = 3'(c - K + 1);
          e.eof  = (r - K + 1 == LAST_OR) && (c - K + 1 == LAST_OC);
          e.win  = make_win(r - K + 1, c - K + 1, key);
          exp_q.push_back(e);
        end
      end
    end
  endfunction

  // ---------------------------------------------------------------- drivers
  task automatic send_pixel(logic sof, int r, int c, logic [DW-1:0] key);
    @(negedge clk);
    wl_en    = 1'b1;
    wl_sof_i = sof;
    for (int ch = 0; ch < NC; ch++) wl_data_i[ch] = pix(ch, r, c, key);
    if (r == K - 1 && c == K - 1) pix22_cyc = cyc + 1;
  endtask

  task automatic idle(int n);
    repeat (n) begin
      @(negedge clk);
      wl_en    = 1'b0;
      wl_sof_i = 1'b0;
    end
  endtask

  task automatic send_frame(logic [DW-1:0] key, int gap_pct, int last_r, int last_c);
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        if (r > last_r || (r == last_r && c > last_c)) return;
        if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) idle(1);
        send_pixel(r == 0 && c == 0, r, c, key);
      end
    end
  endtask

  task automatic send_junk(int n);
    repeat (n) begin
      @(negedge clk);
      wl_en     = 1'b1;
      wl_sof_i  = 1'b0;
      wl_data_i = {8'($urandom), 8'($urandom)};
    end
  endtask

  task automatic clear_queues();
    mon_q.delete();
    mon_cyc.delete();
    exp_q.delete();
  endtask

  // ---------------------------------------------------------------- scoreboard
  task automatic check_windows(string name);
    int n;
    tests++;
    if (mon_q.size() !== exp_q.size()) begin
      failed++;
      $display("FAIL %s_count got %0d windows, expected %0d", name, mon_q.size(), exp_q.size());
    end
    n = (mon_q.size() < exp_q.size()) ? mon_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      tests++;
      if (mon_q[i] !== exp_q[i]) begin
        failed++;
        $display("FAIL %s_win[%0d] got orow=%0d ocol=%0d eof=%0b win=%h expected orow=%0d ocol=%0d eof=%0b win=%h",
                 name, i, mon_q[i].orow, mon_q[i].ocol, mon_q[i].eof, mon_q[i].win,
                 exp_q[i].orow, exp_q[i].ocol, exp_q[i].eof, exp_q[i].win);
      end
    end
    clear_queues();
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    rst_b = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if (wl_win_vld_o !== 1'b0 || wl_eof_o !== 1'b0) begin
      failed++;
      $display("FAIL reset_vld_eof got vld=%0b eof=%0b expected 0 0", wl_win_vld_o, wl_eof_o);
    end
    tests++;
    if (wl_orow_o !== 3'd0 || wl_ocol_o !== 3'd0) begin
      failed++;
      $display("FAIL reset_coord got orow=%0d ocol=%0d expected 0 0", wl_orow_o, wl_ocol_o);
    end
    tests++;
    if (wl_win_o !== '0) begin
      failed++;
      $display("FAIL reset_win got %h expected 0", wl_win_o);
    end
    tests++;
    if (wl_state_o !== IDLE) begin
      failed++;
      $display("FAIL reset_state got %0d expected %0d", wl_state_o, IDLE);
    end
    @(negedge clk);
    rst_b = 1'b1;
    idle(2);
    clear_queues();
  endtask

  task automatic test_continuous();
    rec_t first, last;
    send_frame(8'h00, 0, H - 1, W - 1);
    idle(3);
    tests++;
    if (mon_q.size() !== EXP_COUNT) begin
      failed++;
      $display("FAIL cont_pulses got %0d expected %0d", mon_q.size(), EXP_COUNT);
    end
    if (mon_q.size() > 0) begin
      first = mon_q[0];
      last  = mon_q[mon_q.size() - 1];
      tests++;
      if (mon_cyc[0] !== pix22_cyc) begin
        failed++;
        $display("FAIL cont_latency got cycle %0d expected %0d", mon_cyc[0], pix22_cyc);
      end
      tests++;
      if (first.orow !== 3'd0 || first.ocol !== 3'd0 ||
          first.win[0][0][0] !== 8'h00 || first.win[0][2][2] !== 8'h22) begin
        failed++;
        $display("FAIL cont_first got orow=%0d ocol=%0d w00=%h w22=%h expected 0 0 00 22",
                 first.orow, first.ocol, first.win[0][0][0], first.win[0][2][2]);
      end
      tests++;
      if (last.eof !== 1'b1 || last.orow !== 3'(LAST_OR) || last.ocol !== 3'(LAST_OC) ||
          last.win[0][2][2] !== EXP_LAST_PIX) begin
        failed++;
        $display("FAIL cont_last got eof=%0b orow=%0d ocol=%0d w22=%h expected 1 %0d %0d %h",
                 last.eof, last.orow, last.ocol, last.win[0][2][2], LAST_OR, LAST_OC, EXP_LAST_PIX);
      end
    end
    tests++;
    if (wl_state_o !== DONE) begin
      failed++;
      $display("FAIL cont_state got %0d expected %0d", wl_state_o, DONE);
    end
    expect_frame(8'h00, H - 1, W - 1);
    check_windows("cont");
  endtask

  task automatic test_gaps();
    gap_viol = 0;
    send_frame(8'h00, 30, H - 1, W - 1);
    idle(3);
    tests++;
    if (gap_viol !== 0) begin
      failed++;
      $display("FAIL gaps_vld_after_idle got %0d pulses expected 0", gap_viol);
    end
    expect_frame(8'h00, H - 1, W - 1);
    check_windows("gaps");
  endtask

  task automatic test_sof_restart();
    // Old frame (key 0x88) up to (4,2); the sof lands where (4,3) would be.
    send_frame(8'h88, 0, 4, 2);
    send_frame(8'h00, 0, H - 1, W - 1);
    idle(3);
    expect_frame(8'h88, 4, 2);
    expect_frame(8'h00, H - 1, W - 1);
    check_windows("restart");
  endtask

  task automatic test_reset_mid();
    int vld_seen;
    send_frame(8'h88, 0, 3, 4);
    @(negedge clk);
    rst_b = 1'b0;
    wl_en = 1'b0;
    wl_sof_i = 1'b0;
    #1;
    clear_queues();
    vld_seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (wl_win_vld_o) vld_seen++;
    end
    tests++;
    if (vld_seen !== 0 || wl_eof_o !== 1'b0 || wl_orow_o !== 3'd0 ||
        wl_ocol_o !== 3'd0 || wl_win_o !== '0 || wl_state_o !== IDLE) begin
      failed++;
      $display("FAIL rstmid_outputs got vld_cnt=%0d eof=%0b orow=%0d ocol=%0d state=%0d win=%h expected all 0",
               vld_seen, wl_eof_o, wl_orow_o, wl_ocol_o, wl_state_o, wl_win_o);
    end
    rst_b = 1'b1;
    send_junk(6);
    idle(2);
    tests++;
    if (mon_q.size() !== 0 || wl_win_o !== '0 || wl_state_o !== IDLE) begin
      failed++;
      $display("FAIL rstmid_nosof got windows=%0d state=%0d win=%h expected 0 IDLE 0",
               mon_q.size(), wl_state_o, wl_win_o);
    end
    send_frame(8'h00, 0, H - 1, W - 1);
    idle(3);
    expect_frame(8'h00, H - 1, W - 1);
    check_windows("rstmid");
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    rst_b = 1'b0;
    repeat (2) @(negedge clk);
    rst_b = 1'b1;
    clear_queues();
    send_junk(4);
    idle(2);
    tests++;
    if (mon_q.size() !== 0 || wl_win_o !== '0 || wl_state_o !== IDLE) begin
      failed++;
      $display("FAIL b2b_idle_ignore got windows=%0d state=%0d win=%h expected 0 IDLE 0",
               mon_q.size(), wl_state_o, wl_win_o);
    end
    send_frame(8'h00, 0, H - 1, W - 1);
    send_frame(8'h11, 0, H - 1, W - 1);
    idle(3);
    expect_frame(8'h00, H - 1, W - 1);
    expect_frame(8'h11, H - 1, W - 1);
    check_windows("b2b");
    tests++;
    if (eof_stray !== 0) begin
      failed++;
      $display("FAIL eof_without_vld got %0d expected 0", eof_stray);
    end
  endtask

  initial begin
    test_reset();
    test_continuous();
    test_gaps();
    test_sof_restart();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/win_lbuf.md
# win_lbuf

Parametrised multi-channel line buffer and K×K sliding-window generator for the convolution layers. Accepts a row-major pixel stream per channel, holds K-1 previous image rows, and presents a full K×K window per channel with its output coordinates each time a new valid window position completes. It is the next-generation replacement for the fixed-tap shift register that feeds the layer-1 convolution datapath. It adds frame control, runtime window validity and an optional stride-2 mode.

## Interface
- DATA_WIDTH, 32, bits per pixel.
- IMG_W, 32, image width in pixels (≥ KSIZE).
- IMG_H, 32, image height in rows (≥ KSIZE).
- KSIZE, 5, window edge (≥ 2).
- NUM_CH, 1, parallel channels sharing one control path.
- wl_clk  in  1  clock. One clock; all logic is on the rising edge.
- wl_rst_b  in  1  reset. Asynchronous, active-low.
- wl_en  in  1  input pixel valid; each high cycle is one accepted pixel, with no backpressure.
- wl_sof_i  in  1  start of frame, qualified by wl_en; the accompanying pixel is (0,0).
- wl_data_i  in  [NUM_CH][DATA_WIDTH]  pixel per channel.
- wl_win_o  out  [NUM_CH][KSIZE][KSIZE][DATA_WIDTH]  window, indexed [ch][row][col]. [0][0] is top-left (oldest). [K-1][K-1] is the newest pixel.
- wl_win_vld_o  out  1  window valid, high for one cycle per window.
- wl_orow_o  out  $clog2(IMG_H)  output row (window top row).
- wl_ocol_o  out  $clog2(IMG_W)  output column (window left column).
- wl_eof_o  out  1  high together with wl_win_vld_o on the frame's last window.

## Operation
- FSM states:
  - IDLE → FILL on wl_en&wl_sof_i.
  - FILL → RUN when the first pixel of row K-1 is accepted.
  - RUN → DONE when pixel (IMG_H-1, IMG_W-1) is accepted.
  - DONE → FILL on wl_en&wl_sof_i.
- wl_en without wl_sof_i in IDLE or DONE is ignored: no shift, no counter change.
- Counters:
  - col_cnt wraps 0..IMG_W-1.
  - row_cnt increments on the wrap and runs 0..IMG_H-1.
  - Both advance only on an accepted pixel.
- Line buffer: per channel, K-1 row delay lines of IMG_W entries, shifted only on an accepted pixel. The buffer is not reset.
- Window registers:
  - On each accepted pixel, every window row shifts left one column.
  - Column K-1 loads the line-buffer taps (rows 0..K-2) and wl_data_i (row K-1).
- Window valid rule: an accepted pixel at (r,c) with r≥K-1 and c≥K-1 produces a window with orow=r-K+1 and ocol=c-K+1.
- Count: (IMG_H-K+1)·(IMG_W-K+1) windows per frame.
- wl_sof_i in FILL or RUN abandons the current frame and restarts counters with this pixel as (0,0). The gating rule guarantees no stale-frame pixel ever appears in a valid window.
- Reset mid-frame: everything returns to IDLE with outputs zero. The next frame requires wl_sof_i.

## Timing
- Latency: 1 cycle. wl_win_vld_o, wl_win_o, wl_orow_o, wl_ocol_o and wl_eof_o are registered in the cycle after the accepting edge.
- wl_win_vld_o is low in any cycle following a cycle with wl_en low. wl_win_o holds its value while wl_en is low.
- Reset values: wl_win_o=0, wl_win_vld_o=0, wl_orow_o=0, wl_ocol_o=0, wl_eof_o=0. State is IDLE and counters are 0.
- Back-to-back frames: wl_sof_i is legal in the cycle immediately after the last pixel, with no bubble needed.

## Configuration
- WIN_LBUF_STRIDE2_EN defined: wl_win_vld_o is additionally gated so it asserts only when orow and ocol are both even. wl_eof_o marks the last such window.
- WIN_LBUF_STRIDE2_EN undefined: stride 1, as above.
- Line buffering and shifting are identical in both modes.

## Structure
- Package win_lbuf_pkg holds the state enum typedef (IDLE, FILL, RUN, DONE) and the default parameter constants.
- Counter widths are localparams in the module.
- Sub-module lbuf_row: one enabled IMG_W-deep, DATA_WIDTH-wide delay line with an output tap. It is instantiated (K-1)·NUM_CH times via generate.

## Test plan
Common setup: IMG_W=8, IMG_H=8, KSIZE=3, NUM_CH=2. Pixel (r,c) = r·16+c on ch0 and its bitwise inverse on ch1.
- Continuous frame: first wl_win_vld_o comes one cycle after pixel (2,2), with orow=0, ocol=0, win[0][0][0]=0x00 and win[0][2][2]=0x22. The frame yields exactly 36 valid pulses. The last has eof=1, orow=5, ocol=5 and win[0][2][2]=0x77.
- Random wl_en gaps (≈30% idle): the window sequence, values and count are identical to the continuous frame, and vld never asserts after an idle cycle.
- wl_sof_i reasserted at pixel (4,3): no vld until new pixel (2,2). The first new window has orow=0, ocol=0 and contains only new-frame data.
- wl_rst_b low at pixel (3,5) for 5 cycles: all outputs are 0. Pixels sent without sof are ignored, and a following sof frame produces the full 36 windows.
- Pixels in IDLE without sof followed by sof, and back-to-back frames with no bubble: there is no output before the sof, and both frames are correct.
- With WIN_LBUF_STRIDE2_EN defined: 9 windows at orow/ocol ∈ {0,2,4}. eof comes with orow=4, ocol=4 and win[0][2][2]=0x66.
